// File: rtl/nxs_nonce_dispatcher_pkg.sv
// Shared types and constants for the Nexus nonce dispatcher slice.
// Used by every rtl/ file through import nxs_pkg::*.
package nxs_pkg;

  localparam int unsigned NXS_HASH_LATENCY = 72;
  localparam int unsigned NXS_NONCE_W      = 64;
  localparam int unsigned NXS_HDR_W        = 1024;
  localparam int unsigned NXS_COUNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MINING = 2'd1,
    DRAIN  = 2'd2
  } nxs_state_t;

  typedef struct packed {
    logic [NXS_NONCE_W-1:0] nonce;
    logic [NXS_NONCE_W-1:0] hash;
  } nxs_result_t;

  function automatic logic [NXS_HDR_W-1:0] nxs_insert_nonce(
    input logic [NXS_HDR_W-1:0]   hdr,
    input logic [NXS_NONCE_W-1:0] nonce,
    input int unsigned            lsb
  );
    logic [NXS_HDR_W-1:0] r;
    r = hdr;
    r[lsb +: NXS_NONCE_W] = nonce;
    return r;
  endfunction

endpackage

// File: rtl/nxs_nonce_dispatcher_if.sv
// Job-offer and hit-result channels between the host side and the dispatcher.
// master = host/UART side, slave = nxs_nonce_dispatcher.
interface nxs_nonce_dispatcher_if;
  import nxs_pkg::*;

  logic                   work_valid;
  logic                   work_ready;
  logic [NXS_HDR_W-1:0]   work_data;
  logic [NXS_NONCE_W-1:0] work_nonce;
  logic [NXS_COUNT_W-1:0] work_count;
  logic [NXS_NONCE_W-1:0] work_target;

  logic                   result_valid;
  logic                   result_ready;
  logic [NXS_NONCE_W-1:0] result_nonce;
  logic [NXS_NONCE_W-1:0] result_hash;

  modport master (
    output work_valid, work_data, work_nonce, work_count, work_target, result_ready,
    input  work_ready, result_valid, result_nonce, result_hash
  );

  modport slave (
    input  work_valid, work_data, work_nonce, work_count, work_target, result_ready,
    output work_ready, result_valid, result_nonce, result_hash
  );

endinterface

// File: rtl/nxs_nonce_dispatcher_fifo.sv
// nxs_result_fifo: small synchronous hit FIFO with async reset; a push while
// full only lands when a pop happens in the same cycle.
module nxs_result_fifo
  import nxs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  nxs_result_t push_data,
  input  logic        pop,
  output nxs_result_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  nxs_result_t     mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/nxs_nonce_dispatcher.sv
// Feeds the 72-stage Nexus Keccak pipeline one nonce per clock and queues hits.
// Optional NXS_DISPATCH_STATS_EN adds stat_hashes / stat_dropped counters.
module nxs_nonce_dispatcher
  import nxs_pkg::*;
#(
  parameter int unsigned LATENCY   = NXS_HASH_LATENCY,
  parameter int unsigned NONCE_LSB = 960,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nxs_nonce_dispatcher_if.slave  bus,
  input  logic                   abort,
  output logic [NXS_HDR_W-1:0]   hash_in,
  input  logic [NXS_NONCE_W-1:0] hash_out,
  output logic                   busy,
  output logic                   job_done
`ifdef NXS_DISPATCH_STATS_EN
  ,
  output logic [63:0]            stat_hashes,
  output logic [15:0]            stat_dropped
`endif
);

  nxs_state_t             state;
  nxs_state_t             state_nxt;

  logic                   work_ready_c;
  logic                   accept;
  logic                   issue;
  logic                   abort_act;

  logic [NXS_HDR_W-1:0]   data_q;
  logic [NXS_NONCE_W-1:0] target_q;
  logic [NXS_NONCE_W-1:0] issue_nonce;
  logic [NXS_NONCE_W-1:0] tail_nonce;
  logic [NXS_COUNT_W-1:0] remaining;
  // issue_q marks the cycle hash_in holds a fresh candidate; the hasher samples
  // it on the next edge, which is when the LATENCY-bit valid line picks it up.
  logic                   issue_q;
  logic [LATENCY-1:0]     vline;

  logic                   exit_v;
  logic                   hit;
  logic                   fifo_full;
  logic                   fifo_empty;
  nxs_result_t            fifo_head;
  nxs_result_t            push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    work_ready_c = 1'b0;
    busy         = 1'b1;
    job_done     = 1'b0;
    accept       = 1'b0;
    issue        = 1'b0;
    abort_act    = 1'b0;
    unique case (state)
      IDLE: begin
        busy         = 1'b0;
        work_ready_c = 1'b1;
        if (bus.work_valid) begin
          accept    = 1'b1;
          state_nxt = (bus.work_count == '0) ? DRAIN : MINING;
        end
      end
      MINING: begin
        if (abort) begin
          abort_act = 1'b1;
          state_nxt = IDLE;
        end else begin
          issue = 1'b1;
          if (remaining == NXS_COUNT_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          abort_act = 1'b1;
          state_nxt = IDLE;
        end else if (!issue_q && (vline == '0)) begin
          job_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.work_ready = work_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      target_q    <= '0;
      issue_nonce <= '0;
      tail_nonce  <= '0;
      remaining   <= '0;
      hash_in     <= '0;
      issue_q     <= 1'b0;
      vline       <= '0;
    end else begin
      if (accept) begin
        data_q      <= bus.work_data;
        target_q    <= bus.work_target;
        issue_nonce <= bus.work_nonce;
        tail_nonce  <= bus.work_nonce;
        remaining   <= bus.work_count;
      end
      if (issue) begin
        hash_in     <= nxs_insert_nonce(data_q, issue_nonce, NONCE_LSB);
        issue_nonce <= issue_nonce + NXS_NONCE_W'(1);
        remaining   <= remaining - NXS_COUNT_W'(1);
      end
      if (abort_act) begin
        issue_q <= 1'b0;
        vline   <= '0;
      end else begin
        issue_q <= issue;
        vline   <= {vline[LATENCY-2:0], issue_q};
        if (vline[LATENCY-1]) begin
          tail_nonce <= tail_nonce + NXS_NONCE_W'(1);
        end
      end
    end
  end

  // Results leave the hasher in issue order, so tail_nonce alone names them.
  assign exit_v          = vline[LATENCY-1] && !abort_act;
  assign hit             = exit_v && (hash_out < target_q);
  assign push_data.nonce = tail_nonce;
  assign push_data.hash  = hash_out;

  nxs_result_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hit),
    .push_data (push_data),
    .pop       (bus.result_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.result_valid = !fifo_empty;
  assign bus.result_nonce = fifo_head.nonce;
  assign bus.result_hash  = fifo_head.hash;

`ifdef NXS_DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hashes  <= '0;
      stat_dropped <= '0;
    end else begin
      if (exit_v) begin
        stat_hashes <= stat_hashes + 64'd1;
      end
      if (hit && fifo_full && !bus.result_ready && (stat_dropped != '1)) begin
        stat_dropped <= stat_dropped + 16'd1;
      end
    end
  end
`endif

endmodule
